// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and helpers for the register-file write-port arbiter and for
// any future read-port arbiter built on the same round-robin picker.
//   arb_state_e    : arbiter state (ARB = free arbitration, BURST = locked owner)
//   RF_AW_DEF      : default register address width
//   RF_DW_DEF      : default register data width
//   OH_MAX         : widest one-hot vector accepted by onehot_to_idx (8 requesters)
//   onehot_to_idx  : one-hot (or all-zero) vector to binary index
// -----------------------------------------------------------------------------
package rf_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int RF_AW_DEF = 5;
  localparam int RF_DW_DEF = 32;
  localparam int OH_MAX    = 8;

  // OR-reduction encoder: correct for one-hot input, returns 0 for all-zero.
  function automatic logic [2:0] onehot_to_idx(input logic [OH_MAX-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < OH_MAX; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans valid_i starting at ptr_i and
// wrapping modulo N, and returns the first valid requester.
//   valid_i : per-requester request vector
//   ptr_i   : requester with highest priority this cycle (0..N-1)
//   gnt_o   : one-hot grant (all zero when nothing is valid)
//   idx_o   : binary index of the granted requester (0 when none)
//   any_o   : at least one requester is granted
// -----------------------------------------------------------------------------
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Priority scan from ptr_i; the wrap is an explicit compare so that
  // non-power-of-two N wraps at N rather than at 2**IW.
  always_comb begin
    gnt_o   = {N{1'b0}};
    found_s = 1'b0;
    sum_s   = {(IW+1){1'b0}};
    cand_s  = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum_s >= N_W) begin
        sum_s = sum_s - N_W;
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!found_s && valid_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_o = found_s;
  assign idx_o = IW'(onehot_to_idx(OH_MAX'(gnt_o)));

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port between NUM_REQ writeback
// requesters. Round-robin arbitration over a valid/ready handshake; a granted
// requester may lock the port for up to MAX_BURST back-to-back beats. The write
// is registered, so an accept in cycle N is presented to the register file in
// cycle N+1 with rf_we high for that single cycle.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req_valid    : per-requester write request
//   req_lock     : per-requester request to keep the grant for the next beat
//   req_addr     : packed addresses, requester i at [i*AW +: AW]
//   req_data     : packed data, requester i at [i*DW +: DW]
//   req_ready    : one-hot grant, combinational, forced low while rst_n is low
//   rf_wr/rf_wd  : registered write address / data
//   rf_we        : registered write enable
//   grant_id     : registered index of the last accepted requester
//   busy         : high while a locked burst owns the port
//
// Optional build macro RF_WR_STATS_EN adds:
//   stat_clr     : synchronous clear of all grant counters (wins over increment)
//   stat_grants  : one 16-bit saturating accept counter per requester
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int AW           = RF_AW_DEF,
  parameter int DW           = RF_DW_DEF,
  parameter int MAX_BURST    = 4,
  parameter int ZERO_PROTECT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [AW-1:0]              rf_wr,
  output logic [DW-1:0]              rf_wd,
  output logic                       rf_we,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef RF_WR_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*16-1:0]      stat_grants
`endif
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB_W   = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam bit            LOCK_EN  = (MAX_BURST > 1);
  localparam bit            ZP_EN    = (ZERO_PROTECT != 0);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] rf_wr_q, rf_wr_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          rf_we_q, rf_we_d;
  logic [IW-1:0] grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic [NUM_REQ-1:0] owner_oh_s;
  logic               owner_valid_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               accept_s;
  logic [IW-1:0]      acc_idx_s;
  logic [AW-1:0]      acc_addr_s;
  logic [DW-1:0]      acc_data_s;
  logic               acc_lock_s;
  logic               acc_zero_s;
  logic [CW-1:0]      cnt_inc_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  assign owner_oh_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign owner_valid_s = |(req_valid & owner_oh_s);
  assign cnt_inc_s     = burst_cnt_q + CW'(1'b1);

  // Grant: free round-robin in ARB, owner only (and only while valid) in BURST.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    case (state_q)
      ARB: begin
        ready_s = pick_gnt_s;
      end
      BURST: begin
        if (owner_valid_s) begin
          ready_s = owner_oh_s;
        end else begin
          ready_s = {NUM_REQ{1'b0}};
        end
      end
      default: begin
        ready_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // The grant never covers an invalid requester, so a non-zero grant is an accept.
  assign accept_s  = |ready_s;
  assign req_ready = rst_n ? ready_s : {NUM_REQ{1'b0}};

  // One-hot mux of the accepted beat's address, data and lock request.
  always_comb begin
    acc_addr_s = {AW{1'b0}};
    acc_data_s = {DW{1'b0}};
    acc_lock_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_addr_s = acc_addr_s | (req_addr[i*AW +: AW] & {AW{ready_s[i]}});
      acc_data_s = acc_data_s | (req_data[i*DW +: DW] & {DW{ready_s[i]}});
      acc_lock_s = acc_lock_s | (req_lock[i] & ready_s[i]);
    end
    acc_idx_s  = IW'(onehot_to_idx(OH_MAX'(ready_s)));
    acc_zero_s = ZP_EN && (acc_addr_s == {AW{1'b0}});
  end

  // Next-state: write register, round-robin pointer and burst tracking.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rf_wr_d     = rf_wr_q;
    rf_wd_d     = rf_wd_q;
    rf_we_d     = 1'b0;
    grant_id_d  = grant_id_q;

    // A suppressed address-0 write completes the handshake but leaves the
    // register file port untouched.
    if (accept_s) begin
      grant_id_d = acc_idx_s;
      if (acc_zero_s) begin
        rf_we_d = 1'b0;
      end else begin
        rf_we_d = 1'b1;
        rf_wr_d = acc_addr_s;
        rf_wd_d = acc_data_s;
      end
    end else begin
      rf_we_d = 1'b0;
    end

    case (state_q)
      ARB: begin
        if (pick_any_s) begin
          // Pointer moves past the winner, so a locking owner cannot re-win
          // immediately after its burst while peers are waiting.
          rr_ptr_d = (pick_idx_s == LAST_IDX) ? {IW{1'b0}} : (pick_idx_s + IW'(1'b1));
          if (LOCK_EN && acc_lock_s) begin
            state_d     = BURST;
            owner_d     = pick_idx_s;
            burst_cnt_d = CW'(1'b1);
          end else begin
            state_d     = ARB;
            burst_cnt_d = {CW{1'b0}};
          end
        end else begin
          state_d = ARB;
        end
      end
      BURST: begin
        if (owner_valid_s) begin
          // The beat that reaches MAX_BURST is still taken, then the lock ends.
          if (!acc_lock_s || (cnt_inc_s == MAXB_W)) begin
            state_d     = ARB;
            burst_cnt_d = {CW{1'b0}};
          end else begin
            state_d     = BURST;
            burst_cnt_d = cnt_inc_s;
          end
        end else begin
          state_d     = ARB;
          burst_cnt_d = {CW{1'b0}};
        end
      end
      default: begin
        state_d     = ARB;
        burst_cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= {IW{1'b0}};
      owner_q     <= {IW{1'b0}};
      burst_cnt_q <= {CW{1'b0}};
      rf_wr_q     <= {AW{1'b0}};
      rf_wd_q     <= {DW{1'b0}};
      rf_we_q     <= 1'b0;
      grant_id_q  <= {IW{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rf_wr_q     <= rf_wr_d;
      rf_wd_q     <= rf_wd_d;
      rf_we_q     <= rf_we_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign rf_wr    = rf_wr_q;
  assign rf_wd    = rf_wd_q;
  assign rf_we    = rf_we_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == BURST);

`ifdef RF_WR_STATS_EN
  logic [NUM_REQ*16-1:0] stat_q;

  // Per-requester saturating accept counters; suppressed writes still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= {(NUM_REQ*16){1'b0}};
    end else if (stat_clr) begin
      stat_q <= {(NUM_REQ*16){1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ready_s[i] && (stat_q[i*16 +: 16] != 16'hFFFF)) begin
          stat_q[i*16 +: 16] <= stat_q[i*16 +: 16] + 16'd1;
        end else begin
          stat_q[i*16 +: 16] <= stat_q[i*16 +: 16];
        end
      end
    end
  end

  assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter (NUM_REQ=3, AW=5, DW=32, MAX_BURST=4,
// ZERO_PROTECT=1). Each stimulus cycle checks the combinational grant and busy
// against hand-computed values and queues the register-file write expected on
// the following cycle; an independent monitor pops one entry per cycle and
// compares rf_we, grant_id and (when defined) rf_wr/rf_wd.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_lock;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef RF_WR_STATS_EN
  logic        stat_clr;
  logic [47:0] stat_grants;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .NUM_REQ      (3),
    .AW           (5),
    .DW           (32),
    .MAX_BURST    (4),
    .ZERO_PROTECT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_wr     (rf_wr),
    .rf_wd     (rf_wd),
    .rf_we     (rf_we),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef RF_WR_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  typedef struct packed {
    logic        we;
    logic        known;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [1:0]  gid;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [4:0]  addr_v [3];
  logic [31:0] data_v [3];
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        m_known;
  logic [1:0]  m_gid;

  // One clock of stimulus: drive inputs, check grant/busy, queue the expected write.
  task automatic step(input logic r, input logic [2:0] v, input logic [2:0] lk,
                      input logic [2:0] exp_rdy, input logic exp_busy);
    exp_t rec;
    int   idx;
    @(posedge clk);
    #2;
    rst_n     = r;
    req_valid = v;
    req_lock  = lk;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*5 +: 5]   = addr_v[i];
      req_data[i*32 +: 32] = data_v[i];
    end
    #2;
    vec_cnt++;
    if (req_ready !== exp_rdy) begin
      err_cnt++;
      $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_rdy, $time);
    end
    vec_cnt++;
    if (busy !== exp_busy) begin
      err_cnt++;
      $display("FAIL busy: got %b expected %b (t=%0t)", busy, exp_busy, $time);
    end
    rec.we = 1'b0;
    if (!r) begin
      m_wr    = 5'd0;
      m_wd    = 32'd0;
      m_known = 1'b1;
      m_gid   = 2'd0;
    end else if (exp_rdy != 3'b000) begin
      idx   = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
      m_gid = 2'(idx);
      if (addr_v[idx] == 5'd0) begin
        m_known = 1'b0;
      end else begin
        rec.we  = 1'b1;
        m_wr    = addr_v[idx];
        m_wd    = data_v[idx];
        m_known = 1'b1;
      end
    end
    rec.known = m_known;
    rec.wr    = m_wr;
    rec.wd    = m_wd;
    rec.gid   = m_gid;
    exp_q.push_back(rec);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if (rf_we !== e.we) begin
          err_cnt++;
          $display("FAIL rf_we: got %b expected %b (t=%0t)", rf_we, e.we, $time);
        end
        vec_cnt++;
        if (grant_id !== e.gid) begin
          err_cnt++;
          $display("FAIL grant_id: got %0d expected %0d (t=%0t)", grant_id, e.gid, $time);
        end
        if (e.known) begin
          vec_cnt++;
          if ((rf_wr !== e.wr) || (rf_wd !== e.wd)) begin
            err_cnt++;
            $display("FAIL rf_wr/rf_wd: got %0d/%h expected %0d/%h (t=%0t)",
                     rf_wr, rf_wd, e.wr, e.wd, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = 3'b000;
    req_lock  = 3'b000;
    req_addr  = 15'd0;
    req_data  = 96'd0;
`ifdef RF_WR_STATS_EN
    stat_clr  = 1'b0;
`endif
    m_wr      = 5'd0;
    m_wd      = 32'd0;
    m_known   = 1'b0;
    m_gid     = 2'd0;
    addr_v[0] = 5'd3;  data_v[0] = 32'h0000_0014;
    addr_v[1] = 5'd7;  data_v[1] = 32'h0000_00A1;
    addr_v[2] = 5'd9;  data_v[2] = 32'h0000_00B2;

    // Reset, then a single request from requester 0.
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b1, 3'b001, 3'b000, 3'b001, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);

    // Fresh reset, all three valid without lock: 0,1,2,0,1,2.
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b001, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b010, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b100, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b001, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b010, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b100, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);

    // Requester 1 locks for 6 beats: 4 capped beats, then 2, 0, then 1 again.
    step(1'b1, 3'b010, 3'b010, 3'b010, 1'b0);
    step(1'b1, 3'b111, 3'b010, 3'b010, 1'b1);
    step(1'b1, 3'b111, 3'b010, 3'b010, 1'b1);
    step(1'b1, 3'b111, 3'b010, 3'b010, 1'b1);
    step(1'b1, 3'b111, 3'b010, 3'b100, 1'b0);
    step(1'b1, 3'b111, 3'b010, 3'b001, 1'b0);
    step(1'b1, 3'b111, 3'b010, 3'b010, 1'b0);
    step(1'b1, 3'b111, 3'b000, 3'b010, 1'b1);
    step(1'b1, 3'b101, 3'b000, 3'b100, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);

    // Address 0 from requester 2: handshake completes, write suppressed.
    addr_v[2] = 5'd0;
    data_v[2] = 32'hF0F0_F0F0;
    step(1'b1, 3'b100, 3'b000, 3'b100, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
`ifdef RF_WR_STATS_EN
    vec_cnt++;
    if (stat_grants !== {16'd5, 16'd8, 16'd3}) begin
      err_cnt++;
      $display("FAIL stat_grants: got %h expected %h", stat_grants, {16'd5, 16'd8, 16'd3});
    end
    stat_clr = 1'b1;
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
    stat_clr = 1'b0;
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
    vec_cnt++;
    if (stat_grants !== 48'd0) begin
      err_cnt++;
      $display("FAIL stat_clr: got %h expected 0", stat_grants);
    end
`endif
    addr_v[2] = 5'd9;
    data_v[2] = 32'h0000_00B2;

    // Owner drops valid mid-burst: release without accept, peer granted next.
    step(1'b1, 3'b001, 3'b001, 3'b001, 1'b0);
    step(1'b1, 3'b111, 3'b001, 3'b001, 1'b1);
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b1);
    step(1'b1, 3'b110, 3'b000, 3'b010, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);

    // Reset during beat 2 of a burst by requester 0 (pointer was 1 before reset).
    step(1'b1, 3'b001, 3'b001, 3'b001, 1'b0);
    step(1'b0, 3'b011, 3'b001, 3'b000, 1'b0);
    step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 3'b001, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);

    @(posedge clk);
    #3;
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
